// File: rtl/perceptron_result_reader.sv
// perceptron_result_reader
// Reads a run of 32-bit result words from BRAM and streams the low 16 bits
// of each word to a UART TX FIFO, low byte first, honouring FIFO back-pressure.
//
// Optional feature macro: RESULT_HEADER_EN
//   defined   : each transfer is prefixed with 0xA5 and the word count byte
//   undefined : data bytes only; header states generate no logic
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   enable            : start request, sampled only while idle
//   start_addr        : first BRAM word address, sampled with enable
//   word_count        : number of result words, sampled with enable
//   busy              : high whenever a transfer is in progress
//   send_complete     : one-cycle pulse when a transfer ends
//   bram_read_enable  : one-cycle BRAM read strobe
//   bram_read_addr    : BRAM word address
//   bram_data_in      : BRAM read data, result in [15:0], one-cycle latency
//   uart_buffer_full  : UART TX FIFO full
//   uart_data_out     : byte presented to the FIFO, stable during a stall
//   uart_data_write   : FIFO write strobe
module perceptron_result_reader #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned MAX_WORDS_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [ADDR_W-1:0]      start_addr,
    input  logic [MAX_WORDS_W-1:0] word_count,
    output logic                   busy,
    output logic                   send_complete,
    output logic                   bram_read_enable,
    output logic [ADDR_W-1:0]      bram_read_addr,
    input  logic [31:0]            bram_data_in,
    input  logic                   uart_buffer_full,
    output logic [7:0]             uart_data_out,
    output logic                   uart_data_write
);

    localparam int unsigned HOLD_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        HDR     = 4'd1,
        CNT     = 4'd2,
        READ    = 4'd3,
        WAIT    = 4'd4,
        SEND_LO = 4'd5,
        SEND_HI = 4'd6,
        NEXT    = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_W-1:0]       r_addr;
    logic [ADDR_W-1:0]       w_addr_nxt;
    logic [MAX_WORDS_W-1:0]  r_remaining;
    logic [MAX_WORDS_W-1:0]  w_remaining_nxt;
    logic [HOLD_W-1:0]       r_hold;
    logic [HOLD_W-1:0]       w_hold_nxt;
    logic [BYTE_W-1:0]       r_data_out;
    logic [BYTE_W-1:0]       w_data_out_nxt;
    logic                    r_busy;
    logic                    r_send_complete;
    logic                    r_rd_en;
    logic                    w_tx_state;
    logic                    w_unused_data;

    // Only the low half of each BRAM word carries a result.
    assign w_unused_data = ^bram_data_in[31:HOLD_W];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_hold          <= '0;
            r_data_out      <= '0;
            r_busy          <= 1'b0;
            r_send_complete <= 1'b0;
            r_rd_en         <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_addr          <= w_addr_nxt;
            r_remaining     <= w_remaining_nxt;
            r_hold          <= w_hold_nxt;
            r_data_out      <= w_data_out_nxt;
            r_busy          <= (w_next_state != IDLE);
            r_send_complete <= (w_next_state == DONE);
            r_rd_en         <= (w_next_state == READ);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_next_state    = r_state;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_hold_nxt      = r_hold;
        w_tx_state      = 1'b0;

        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_addr_nxt      = start_addr;
                    w_remaining_nxt = word_count;
`ifdef RESULT_HEADER_EN
                    w_next_state    = HDR;
`else
                    w_next_state    = (word_count == '0) ? DONE : READ;
`endif
                end
            end
`ifdef RESULT_HEADER_EN
            HDR: begin
                w_tx_state = 1'b1;
                if (!uart_buffer_full) begin
                    w_next_state = CNT;
                end
            end
            CNT: begin
                w_tx_state = 1'b1;
                if (!uart_buffer_full) begin
                    w_next_state = (r_remaining == '0) ? DONE : READ;
                end
            end
`endif
            READ: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                // BRAM data is valid one cycle after the read strobe.
                w_hold_nxt   = bram_data_in[HOLD_W-1:0];
                w_next_state = SEND_LO;
            end
            SEND_LO: begin
                w_tx_state = 1'b1;
                if (!uart_buffer_full) begin
                    w_next_state = SEND_HI;
                end
            end
            SEND_HI: begin
                w_tx_state = 1'b1;
                if (!uart_buffer_full) begin
                    w_next_state = NEXT;
                end
            end
            NEXT: begin
                w_remaining_nxt = r_remaining - MAX_WORDS_W'(1);
                w_addr_nxt      = r_addr + ADDR_W'(1);
                w_next_state    = (w_remaining_nxt != '0) ? READ : DONE;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Byte to present in the next state; held unchanged while stalled.
    always_comb begin
        w_data_out_nxt = r_data_out;
        case (w_next_state)
`ifdef RESULT_HEADER_EN
            HDR:     w_data_out_nxt = 8'hA5;
            CNT:     w_data_out_nxt = BYTE_W'(w_remaining_nxt);
`endif
            SEND_LO: w_data_out_nxt = w_hold_nxt[7:0];
            SEND_HI: w_data_out_nxt = w_hold_nxt[15:8];
            default: w_data_out_nxt = r_data_out;
        endcase
    end

    // The write strobe must react to uart_buffer_full in the same cycle so a
    // full FIFO is never written; the state term itself comes from a flop.
    assign uart_data_write  = w_tx_state & ~uart_buffer_full;

    assign busy             = r_busy;
    assign send_complete    = r_send_complete;
    assign bram_read_enable = r_rd_en;
    assign bram_read_addr   = r_addr;
    assign uart_data_out    = r_data_out;

endmodule

// File: tb/tb_perceptron_result_reader.sv
// Self-checking bench for perceptron_result_reader: a BRAM array, a byte/addr
// monitor and a transfer-level reference model of the expected byte stream.
module tb_perceptron_result_reader;

    localparam int unsigned ADDR_W      = 9;
    localparam int unsigned MAX_WORDS_W = 4;
    localparam int          DEPTH       = 512;
`ifdef RESULT_HEADER_EN
    localparam int          HDR_N       = 2;
`else
    localparam int          HDR_N       = 0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   enable;
    logic [ADDR_W-1:0]      start_addr;
    logic [MAX_WORDS_W-1:0] word_count;
    logic                   busy;
    logic                   send_complete;
    logic                   bram_read_enable;
    logic [ADDR_W-1:0]      bram_read_addr;
    logic [31:0]            bram_data_in;
    logic                   uart_buffer_full;
    logic [7:0]             uart_data_out;
    logic                   uart_data_write;

    logic [31:0] mem [DEPTH];
    logic [7:0]  got_bytes[$];
    int          got_addrs[$];
    logic [7:0]  exp_bytes[$];
    int          exp_addrs[$];
    int          n_complete;
    int          wr_full_viol;
    int          n_vec;
    int          n_err;

    perceptron_result_reader #(
        .ADDR_W      (ADDR_W),
        .MAX_WORDS_W (MAX_WORDS_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .start_addr       (start_addr),
        .word_count       (word_count),
        .busy             (busy),
        .send_complete    (send_complete),
        .bram_read_enable (bram_read_enable),
        .bram_read_addr   (bram_read_addr),
        .bram_data_in     (bram_data_in),
        .uart_buffer_full (uart_buffer_full),
        .uart_data_out    (uart_data_out),
        .uart_data_write  (uart_data_write)
    );

    always #5 clk = ~clk;

    // BRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (bram_read_enable) bram_data_in <= mem[bram_read_addr];
    end

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (uart_data_write) begin
            got_bytes.push_back(uart_data_out);
            if (uart_buffer_full) wr_full_viol++;
        end
        if (bram_read_enable) got_addrs.push_back(int'(bram_read_addr));
        if (send_complete) n_complete++;
    end

    // Reference: header (optional), then low/high byte of each word in order.
    function automatic void model_xfer(input int sa, input int wc);
        logic [31:0] w;
        int a;
        exp_bytes.delete();
        exp_addrs.delete();
`ifdef RESULT_HEADER_EN
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'(wc));
`endif
        for (int i = 0; i < wc; i++) begin
            a = (sa + i) % DEPTH;
            w = mem[a];
            exp_addrs.push_back(a);
            exp_bytes.push_back(w[7:0]);
            exp_bytes.push_back(w[15:8]);
        end
    endfunction

    task automatic clear_obs();
        got_bytes.delete();
        got_addrs.delete();
        n_complete   = 0;
        wr_full_viol = 0;
    endtask

    task automatic start_xfer(input int sa, input int wc);
        @(posedge clk); #1;
        enable     = 1'b1;
        start_addr = ADDR_W'(sa);
        word_count = MAX_WORDS_W'(wc);
        @(posedge clk); #1;
        enable     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_full, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if (n_complete != 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rnd_full) uart_buffer_full = ($urandom_range(0, 2) == 0);
        end
        uart_buffer_full = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_vec++;
        if ({busy, send_complete, bram_read_enable, uart_data_write} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_strobes: got %b expected 0000",
                     {busy, send_complete, bram_read_enable, uart_data_write});
        end
        n_vec++;
        if (uart_data_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data_out: got %h expected 00", uart_data_out);
        end
        n_vec++;
        if (bram_read_addr !== '0) begin
            n_err++;
            $display("FAIL reset_read_addr: got %h expected 000", bram_read_addr);
        end
    endtask

    task automatic test_transfer(input string name, input int sa, input int wc,
                                 input bit rnd_full);
        bit ok;
        model_xfer(sa, wc);
        clear_obs();
        start_xfer(sa, wc);
        wait_done(2000, rnd_full, ok);
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_timeout: no send_complete within budget", name);
        end
        n_vec++;
        if (got_bytes.size() != exp_bytes.size()) begin
            n_err++;
            $display("FAIL %s_byte_count: got %0d expected %0d", name,
                     got_bytes.size(), exp_bytes.size());
        end
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
            n_vec++;
            if (got_bytes[i] !== exp_bytes[i]) begin
                n_err++;
                $display("FAIL %s_byte[%0d]: got %h expected %h", name, i,
                         got_bytes[i], exp_bytes[i]);
            end
        end
        n_vec++;
        if (got_addrs != exp_addrs) begin
            n_err++;
            $display("FAIL %s_read_addrs: got %0d reads (first %0d) expected %0d reads (first %0d)",
                     name, got_addrs.size(), (got_addrs.size() > 0) ? got_addrs[0] : -1,
                     exp_addrs.size(), (exp_addrs.size() > 0) ? exp_addrs[0] : -1);
        end
        n_vec++;
        if (n_complete != 1) begin
            n_err++;
            $display("FAIL %s_complete_pulses: got %0d expected 1", name, n_complete);
        end
        n_vec++;
        if (wr_full_viol != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_full_write_or_busy: viol %0d busy %b expected 0/0", name,
                     wr_full_viol, busy);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int sa;
        logic [7:0] hi;
        sa = int'($urandom_range(0, DEPTH - 1));
        mem[sa] = $urandom();
        model_xfer(sa, 1);
        hi = exp_bytes[HDR_N + 1];
        clear_obs();
        start_xfer(sa, 1);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); #1;
            if (got_bytes.size() == HDR_N + 1) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL stall_low_byte_timeout: got %0d bytes expected %0d", got_bytes.size(),
                     HDR_N + 1);
        end
        @(posedge clk); #1;
        uart_buffer_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            n_vec++;
            if (uart_data_write !== 1'b0 || uart_data_out !== hi) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: write %b data %h expected 0 %h", k,
                         uart_data_write, uart_data_out, hi);
            end
        end
        @(posedge clk); #1;
        uart_buffer_full = 1'b0;
        @(negedge clk); #1;
        n_vec++;
        if (uart_data_write !== 1'b1 || uart_data_out !== hi) begin
            n_err++;
            $display("FAIL stall_release: write %b data %h expected 1 %h", uart_data_write,
                     uart_data_out, hi);
        end
        wait_done(100, 1'b0, ok);
        n_vec++;
        if (!ok || got_bytes != exp_bytes || n_complete != 1 || wr_full_viol != 0) begin
            n_err++;
            $display("FAIL stall_stream: done %b bytes %0d expected %0d complete %0d viol %0d",
                     ok, got_bytes.size(), exp_bytes.size(), n_complete, wr_full_viol);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int sa;
        sa = int'($urandom_range(0, DEPTH - 1));
        clear_obs();
        start_xfer(sa, 2);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); #1;
            if (got_bytes.size() == 1) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL rstmid_first_byte: got %0d bytes expected 1", got_bytes.size());
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, send_complete, bram_read_enable, uart_data_write} !== 4'b0000 ||
            uart_data_out !== 8'h00 || bram_read_addr !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs: strobes %b data %h addr %h expected 0000 00 000",
                     {busy, send_complete, bram_read_enable, uart_data_write},
                     uart_data_out, bram_read_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        n_vec++;
        if (got_bytes.size() != 1 || n_complete != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_quiet: bytes %0d complete %0d busy %b expected 1 0 0",
                     got_bytes.size(), n_complete, busy);
        end
        test_transfer("after_reset", int'($urandom_range(0, DEPTH - 1)), 3, 1'b0);
    endtask

    task automatic test_enable_busy();
        bit ok;
        int sa;
        sa = int'($urandom_range(0, DEPTH - 1));
        model_xfer(sa, 3);
        clear_obs();
        start_xfer(sa, 3);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            enable     = (k % 3 == 1);
            start_addr = ADDR_W'($urandom());
            word_count = MAX_WORDS_W'($urandom());
        end
        enable = 1'b0;
        wait_done(200, 1'b0, ok);
        repeat (5) @(negedge clk);
        #1;
        n_vec++;
        if (!ok || got_bytes != exp_bytes || got_addrs != exp_addrs) begin
            n_err++;
            $display("FAIL enbusy_stream: done %b bytes %0d expected %0d reads %0d expected %0d",
                     ok, got_bytes.size(), exp_bytes.size(), got_addrs.size(), exp_addrs.size());
        end
        n_vec++;
        if (n_complete != 1) begin
            n_err++;
            $display("FAIL enbusy_complete: got %0d expected 1", n_complete);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        start_addr = '0;
        word_count = '0;
        uart_buffer_full = 1'b0;
        bram_data_in = '0;
        clear_obs();
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();

        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        mem[9'h010] = 32'h0000_1234;
        mem[9'h011] = 32'h0000_ABCD;
        test_transfer("basic", 'h010, 2, 1'b0);
        test_transfer("wrap", 'h1FF, 2, 1'b0);
        mem[0] = 32'h0000_00FF;
        test_transfer("one_word", 0, 1, 1'b0);
        test_transfer("zero_words", int'($urandom_range(0, DEPTH - 1)), 0, 1'b0);
        test_transfer("max_words", DEPTH - 7, 15, 1'b1);
        test_stall();
        test_reset_mid();
        test_enable_busy();
        for (int t = 0; t < 20; t++) begin
            test_transfer("random", int'($urandom_range(0, DEPTH - 1)),
                          int'($urandom_range(0, 15)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
